// File: rtl/capture_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : capture_dump_ctrl
// Description : Scan-inject capture/dump sequencer. Holds the capture enable
//               for CAPTURE_CYCLES cycles, then drains the eight one-bit scan
//               channels in order ch0..ch7. Each channel's serial bits are
//               packed LSB-first into bytes and handed to a byte-wide UART
//               transmitter through a busy/strobe handshake. Loops forever.
//
// Parameters  : CAPTURE_CYCLES  cycles o_c_en is held high per capture (>=1)
//               HDR_BYTE        channel header base (header = HDR_BYTE | ch)
//
// Options     : CDCTRL_CH_HEADER_EN  when defined, a header byte HDR_BYTE|ch
//                                    is sent on entry to every channel before
//                                    its data is shifted.
//
// Ports       : clk             system clock, rising edge
//               rst             synchronous active-high reset
//               i_ch_out        bit i = serial data bit from channel i
//               i_ch_out_vld    bit i = i_ch_out[i] valid this cycle
//               i_ch_out_done   bit i = channel i has no more bits (level)
//               i_serial_busy   UART transmitter busy
//               o_c_en          capture enable to all channels
//               o_dump_en       one-hot shift permission to selected channel
//               o_serial_en     1-cycle strobe: load o_serial_tx into UART
//               o_serial_tx     byte to transmit (held between strobes)
//
// Revision    : 1.0  initial release
// ============================================================================
module capture_dump_ctrl #(
    parameter int         CAPTURE_CYCLES = 16,
    parameter logic [7:0] HDR_BYTE       = 8'hA0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_ch_out,
    input  logic [7:0] i_ch_out_vld,
    input  logic [7:0] i_ch_out_done,
    input  logic       i_serial_busy,
    output logic       o_c_en,
    output logic [7:0] o_dump_en,
    output logic       o_serial_en,
    output logic [7:0] o_serial_tx
);

    localparam int             c_cap_w   = $clog2(CAPTURE_CYCLES + 1);
    localparam logic [c_cap_w-1:0] c_cap_max = c_cap_w'(CAPTURE_CYCLES);

    typedef enum logic [1:0] {
        S_CAPTURE   = 2'd0,
        S_DUMP      = 2'd1,
        S_SEND      = 2'd2,
        S_SEND_WAIT = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cap_w-1:0] r_cap_cnt;
    logic [2:0]         r_ch;
    logic [3:0]         r_cnt;
    logic [7:0]         r_sr;
    logic [7:0]         r_byte;
    logic               r_last;
    logic               r_c_en;
    logic [7:0]         r_dump_en;
    logic               r_serial_en;
    logic [7:0]         r_serial_tx;

    logic               w_vld;
    logic               w_bit;
    logic               w_done;
    logic [7:0]         w_sr_next;
    logic [3:0]         w_cnt_next;
    logic [2:0]         w_enter_ch;
    state_t             w_enter_state;
    logic [7:0]         w_enter_dump;
`ifdef CDCTRL_CH_HEADER_EN
    logic [7:0]         w_enter_byte;
`endif

    // Datapath of the selected channel and the "enter next channel" target.
    // Leaving CAPTURE always enters ch0; otherwise entry is to ch+1.
    always_comb begin
        w_vld      = i_ch_out_vld[r_ch];
        w_bit      = i_ch_out[r_ch];
        w_done     = i_ch_out_done[r_ch];
        w_sr_next  = r_sr;
        if (w_vld) begin
            w_sr_next[r_cnt[2:0]] = w_bit;
        end
        w_cnt_next = r_cnt + {3'd0, w_vld};
        w_enter_ch = (r_state == S_CAPTURE) ? 3'd0 : (r_ch + 3'd1);
`ifdef CDCTRL_CH_HEADER_EN
        // Header goes out first; the channel stays stalled until it is sent.
        w_enter_state = S_SEND;
        w_enter_dump  = 8'h00;
        w_enter_byte  = HDR_BYTE | {5'd0, w_enter_ch};
`else
        w_enter_state = S_DUMP;
        w_enter_dump  = 8'h01 << w_enter_ch;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_CAPTURE;
            r_cap_cnt   <= '0;
            r_ch        <= 3'd0;
            r_cnt       <= 4'd0;
            r_sr        <= 8'h00;
            r_byte      <= 8'h00;
            r_last      <= 1'b0;
            r_c_en      <= 1'b0;
            r_dump_en   <= 8'h00;
            r_serial_en <= 1'b0;
            r_serial_tx <= 8'h00;
        end else begin
            r_serial_en <= 1'b0;
            case (r_state)
                S_CAPTURE: begin
                    if (r_cap_cnt == c_cap_max) begin
                        r_c_en    <= 1'b0;
                        r_cap_cnt <= '0;
                        r_ch      <= w_enter_ch;
                        r_cnt     <= 4'd0;
                        r_sr      <= 8'h00;
                        r_state   <= w_enter_state;
                        r_dump_en <= w_enter_dump;
`ifdef CDCTRL_CH_HEADER_EN
                        r_byte    <= w_enter_byte;
                        r_last    <= 1'b0;
`endif
                    end else begin
                        r_c_en    <= 1'b1;
                        r_cap_cnt <= r_cap_cnt + c_cap_w'(1);
                    end
                end

                S_DUMP: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= w_cnt_next;
                    // The valid bit of this cycle is absorbed before done is
                    // honoured; a byte completed together with done is the
                    // channel's final byte (no pad byte follows it).
                    if ((w_cnt_next == 4'd8) || (w_done && (w_cnt_next != 4'd0))) begin
                        r_byte    <= w_sr_next;
                        r_last    <= w_done;
                        r_cnt     <= 4'd0;
                        r_sr      <= 8'h00;
                        r_dump_en <= 8'h00;
                        r_state   <= S_SEND;
                    end else if (w_done) begin
                        r_cnt <= 4'd0;
                        r_sr  <= 8'h00;
                        if (r_ch == 3'd7) begin
                            r_ch      <= 3'd0;
                            r_cap_cnt <= '0;
                            r_dump_en <= 8'h00;
                            r_state   <= S_CAPTURE;
                        end else begin
                            r_ch      <= w_enter_ch;
                            r_state   <= w_enter_state;
                            r_dump_en <= w_enter_dump;
`ifdef CDCTRL_CH_HEADER_EN
                            r_byte    <= w_enter_byte;
                            r_last    <= 1'b0;
`endif
                        end
                    end
                end

                S_SEND: begin
                    if (!i_serial_busy) begin
                        r_serial_en <= 1'b1;
                        r_serial_tx <= r_byte;
                        r_state     <= S_SEND_WAIT;
                    end
                end

                S_SEND_WAIT: begin
                    // One dead cycle so the UART can raise busy before the
                    // next byte can be offered.
                    if (!r_last) begin
                        r_dump_en <= 8'h01 << r_ch;
                        r_state   <= S_DUMP;
                    end else if (r_ch == 3'd7) begin
                        r_ch      <= 3'd0;
                        r_cap_cnt <= '0;
                        r_dump_en <= 8'h00;
                        r_state   <= S_CAPTURE;
                    end else begin
                        r_ch      <= w_enter_ch;
                        r_state   <= w_enter_state;
                        r_dump_en <= w_enter_dump;
`ifdef CDCTRL_CH_HEADER_EN
                        r_byte    <= w_enter_byte;
                        r_last    <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state <= S_CAPTURE;
                end
            endcase
        end
    end

    assign o_c_en      = r_c_en;
    assign o_dump_en   = r_dump_en;
    assign o_serial_en = r_serial_en;
    assign o_serial_tx = r_serial_tx;

endmodule
`default_nettype wire

// File: tb/tb_capture_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_dump_ctrl
// Description : Self-checking bench for capture_dump_ctrl. A procedural model
//               walks the capture / per-channel dump / send sequence and is
//               compared with the DUT every cycle; directed literal checks
//               pin the expected bytes and timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_capture_dump_ctrl;

    localparam int CAP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ch_out  = 8'h00;
    logic [7:0] ch_vld  = 8'h00;
    logic [7:0] ch_done = 8'h00;
    logic       busy    = 1'b0;
    logic       c_en;
    logic [7:0] dump_en;
    logic       sen;
    logic [7:0] tx;

    int n_vec = 0;
    int n_err = 0;

    capture_dump_ctrl #(.CAPTURE_CYCLES(CAP), .HDR_BYTE(8'hA0)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ch_out      (ch_out),
        .i_ch_out_vld  (ch_vld),
        .i_ch_out_done (ch_done),
        .i_serial_busy (busy),
        .o_c_en        (c_en),
        .o_dump_en     (dump_en),
        .o_serial_en   (sen),
        .o_serial_tx   (tx)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: expected output values after the most recent rising edge.
    // ------------------------------------------------------------------
    logic       m_c_en  = 1'b0;
    logic [7:0] m_dump  = 8'h00;
    logic       m_sen   = 1'b0;
    logic [7:0] m_tx    = 8'h00;
    logic       m_abort = 1'b0;
    logic       m_valid = 1'b0;

    task automatic m_step();
        @(posedge clk);
        m_valid = 1'b1;
        m_sen   = 1'b0;
        if (rst) begin
            m_c_en  = 1'b0;
            m_dump  = 8'h00;
            m_tx    = 8'h00;
            m_abort = 1'b1;
        end
    endtask

    // Offer one byte: wait for busy low, strobe, then the dead cycle.
    task automatic m_send(input logic [7:0] b);
        forever begin
            m_step();
            if (m_abort) return;
            if (!busy) begin
                m_sen = 1'b1;
                m_tx  = b;
                break;
            end
        end
        m_step();
    endtask

    // Called at the edge on which channel c is entered; returns at the edge
    // on which the channel is left.
    task automatic m_channel(input int c);
        logic [7:0] sr;
        logic [3:0] cnt;
        logic       fin;
        sr  = 8'h00;
        cnt = 4'd0;
`ifdef CDCTRL_CH_HEADER_EN
        m_dump = 8'h00;
        m_send(8'hA0 | 8'(c));
        if (m_abort) return;
`endif
        m_dump = 8'(1 << c);
        forever begin
            m_step();
            if (m_abort) return;
            if (ch_vld[c]) begin
                sr[cnt[2:0]] = ch_out[c];
                cnt = cnt + 4'd1;
            end
            if (cnt == 4'd8 || (ch_done[c] && cnt != 4'd0)) begin
                fin    = ch_done[c];
                m_dump = 8'h00;
                m_send(sr);
                if (m_abort) return;
                if (fin) begin
                    m_dump = 8'h00;
                    return;
                end
                sr     = 8'h00;
                cnt    = 4'd0;
                m_dump = 8'(1 << c);
            end else if (ch_done[c]) begin
                m_dump = 8'h00;
                return;
            end
        end
    endtask

    task automatic m_sweep();
        for (int k = 0; k < CAP; k++) begin
            m_step();
            if (m_abort) return;
            m_c_en = 1'b1;
        end
        m_step();
        if (m_abort) return;
        m_c_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            m_channel(c);
            if (m_abort) return;
        end
    endtask

    initial begin
        forever begin
            m_abort = 1'b0;
            m_sweep();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_vec++;
                if (c_en !== m_c_en || dump_en !== m_dump || sen !== m_sen || tx !== m_tx) begin
                    n_err++;
                    $display("FAIL model t=%0t: got c_en=%b dump_en=%02h serial_en=%b serial_tx=%02h expected c_en=%b dump_en=%02h serial_en=%b serial_tx=%02h",
                             $time, c_en, dump_en, sen, tx, m_c_en, m_dump, m_sen, m_tx);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Shift 8 bits LSB-first on channel c; done asserted with the last bit
    // when with_done is set. Returns at the negedge after the 8th edge.
    task automatic shift_byte(input int c, input logic [7:0] val, input logic with_done);
        for (int i = 0; i < 8; i++) begin
            ch_vld    = 8'(1 << c);
            ch_out    = val[i] ? 8'(1 << c) : 8'h00;
            ch_done   = (with_done && i == 7) ? 8'(1 << c) : 8'h00;
            @(negedge clk);
        end
        ch_vld  = 8'h00;
        ch_out  = 8'h00;
        ch_done = 8'h00;
    endtask

    initial begin
        logic [7:0] pat;
        repeat (3) @(negedge clk);
        chk("reset_c_en", {7'd0, c_en}, 8'h00);
        chk("reset_dump_en", dump_en, 8'h00);
        rst = 1'b0;

        // Capture phase: c_en high for edges 1..16, then ch0 selected.
        @(negedge clk);
        chk("cap_first_c_en", {7'd0, c_en}, 8'h01);
        repeat (CAP - 1) @(negedge clk);
        chk("cap_last_c_en", {7'd0, c_en}, 8'h01);
        chk("cap_last_dump", dump_en, 8'h00);
        @(negedge clk);
        chk("cap_exit_c_en", {7'd0, c_en}, 8'h00);
        chk("cap_exit_dump", dump_en, 8'h01);

        // Full byte on ch0: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
        pat = 8'b0100_1101;
        shift_byte(0, pat, 1'b0);
        chk("byte0_stall_dump", dump_en, 8'h00);
        @(negedge clk);
        chk("byte0_strobe", {7'd0, sen}, 8'h01);
        chk("byte0_tx", tx, 8'h4D);
        chk("model_tx_4D", m_tx, 8'h4D);
        @(negedge clk);
        chk("byte0_strobe_end", {7'd0, sen}, 8'h00);
        chk("byte0_back_dump", dump_en, 8'h01);

        // Level done with nothing pending steps channels 0 -> 1 -> 2.
        ch_done = 8'hFF;
        @(negedge clk);
        chk("skip_dump_02", dump_en, 8'h02);
        @(negedge clk);
        chk("skip_dump_04", dump_en, 8'h04);
        chk("skip_c_en", {7'd0, c_en}, 8'h00);
        ch_done = 8'h00;

        // Three bits 1,1,1 on ch2, then done -> padded byte 8'h07, then ch3.
        for (int i = 0; i < 3; i++) begin
            ch_vld = 8'h04;
            ch_out = 8'h04;
            @(negedge clk);
        end
        ch_vld  = 8'h00;
        ch_out  = 8'h00;
        ch_done = 8'h04;
        @(negedge clk);
        ch_done = 8'h00;
        chk("pad_stall_dump", dump_en, 8'h00);
        @(negedge clk);
        chk("pad_strobe", {7'd0, sen}, 8'h01);
        chk("pad_tx", tx, 8'h07);
        chk("model_tx_07", m_tx, 8'h07);
        @(negedge clk);
        chk("pad_next_dump", dump_en, 8'h08);

        // ch3 full byte 8'hC3 with done on the last bit, UART busy: stall,
        // then strobe, then straight to ch4 with no pad byte.
        busy = 1'b1;
        pat  = 8'hC3;
        shift_byte(3, pat, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("busy_no_strobe", {7'd0, sen}, 8'h00);
            chk("busy_dump_zero", dump_en, 8'h00);
            @(negedge clk);
        end
        busy = 1'b0;
        @(negedge clk);
        chk("busy_drop_strobe", {7'd0, sen}, 8'h01);
        chk("busy_drop_tx", tx, 8'hC3);
        @(negedge clk);
        chk("full_done_next_dump", dump_en, 8'h10);

        // ch4: bit 0 alone, then bit 1 together with done -> 8'h02.
        ch_vld = 8'h10; ch_out = 8'h00;
        @(negedge clk);
        ch_vld = 8'h10; ch_out = 8'h10; ch_done = 8'h10;
        @(negedge clk);
        ch_vld = 8'h00; ch_out = 8'h00; ch_done = 8'h00;
        @(negedge clk);
        chk("samecyc_strobe", {7'd0, sen}, 8'h01);
        chk("samecyc_tx", tx, 8'h02);
        @(negedge clk);
        chk("samecyc_next_dump", dump_en, 8'h20);
        chk("hold_tx", tx, 8'h02);

        // Done through ch5..ch7 wraps into a new capture phase.
        ch_done = 8'hFF;
        @(negedge clk);
        chk("wrap_dump_40", dump_en, 8'h40);
        @(negedge clk);
        chk("wrap_dump_80", dump_en, 8'h80);
        @(negedge clk);
        chk("wrap_dump_00", dump_en, 8'h00);
        chk("wrap_c_en_lo", {7'd0, c_en}, 8'h00);
        ch_done = 8'h00;
        @(negedge clk);
        chk("wrap_c_en_first", {7'd0, c_en}, 8'h01);
        repeat (CAP - 1) @(negedge clk);
        chk("wrap_c_en_last", {7'd0, c_en}, 8'h01);
        @(negedge clk);
        chk("wrap_dump_01", dump_en, 8'h01);

        // Reset mid-byte: partial bits are discarded.
        for (int i = 0; i < 3; i++) begin
            ch_vld = 8'h01;
            ch_out = 8'h01;
            @(negedge clk);
        end
        ch_vld = 8'h00;
        ch_out = 8'h00;
        rst    = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx, 8'h00);
        chk("midrst_dump", dump_en, 8'h00);
        chk("midrst_c_en", {7'd0, c_en}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_c_en_first", {7'd0, c_en}, 8'h01);
        repeat (CAP) @(negedge clk);
        chk("midrst_dump_01", dump_en, 8'h01);
        pat = 8'hF0;
        shift_byte(0, pat, 1'b0);
        @(negedge clk);
        chk("midrst_strobe", {7'd0, sen}, 8'h01);
        chk("midrst_fresh_tx", tx, 8'hF0);
        @(negedge clk);
        chk("midrst_back_dump", dump_en, 8'h01);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
